// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the memory arbiter: states, access-size codes
// and the IO window mask.
package mem_arbiter_pkg;

  localparam logic        TRUE       = 1'b1;
  localparam logic        FALSE      = 1'b0;
  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite
  } state_e;

  localparam logic [5:0] SIZE_BYTE = 6'd1;
  localparam logic [5:0] SIZE_HALF = 6'd2;
  localparam logic [5:0] SIZE_WORD = 6'd4;

  // Writes whose address has both of these bits set land in the UART window.
  localparam logic [31:0] IO_BASE_MASK = 32'h0003_0000;

  // Unknown size codes fall back to a full word.
  function automatic logic [2:0] decode_size(input logic [5:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the RAM-side, fetch-side and load/store-side signals of the arbiter.
// slave is the arbiter's view; master is the view of the pipeline and RAM.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [31:0]           mem_a;
  logic                  mem_wr;
  logic                  io_buffer_full;

  logic                  in_fetch_ce;
  logic [31:0]           in_fetch_addr;
  logic                  out_fetch_done;
  logic [DATA_WIDTH-1:0] out_fetch_data;

  logic                  in_ls_ce;
  logic                  in_ls_wr;
  logic [5:0]            in_ls_size;
  logic                  in_ls_signed;
  logic [31:0]           in_ls_addr;
  logic [DATA_WIDTH-1:0] in_ls_wdata;
  logic                  out_ls_done;
  logic [DATA_WIDTH-1:0] out_ls_data;

  logic                  in_rob_misbranch;

  modport slave (
    input  mem_din, io_buffer_full,
    input  in_fetch_ce, in_fetch_addr,
    input  in_ls_ce, in_ls_wr, in_ls_size, in_ls_signed, in_ls_addr, in_ls_wdata,
    input  in_rob_misbranch,
    output mem_dout, mem_a, mem_wr,
    output out_fetch_done, out_fetch_data,
    output out_ls_done, out_ls_data
  );

  modport master (
    output mem_din, io_buffer_full,
    output in_fetch_ce, in_fetch_addr,
    output in_ls_ce, in_ls_wr, in_ls_size, in_ls_signed, in_ls_addr, in_ls_wdata,
    output in_rob_misbranch,
    input  mem_dout, mem_a, mem_wr,
    input  out_fetch_done, out_fetch_data,
    input  out_ls_done, out_ls_data
  );

endinterface

// File: rtl/mem_byte_assembler.sv
// Packs the captured low bytes and the final byte into a little-endian word and
// applies sign or zero extension for byte and halfword loads.
module mem_byte_assembler
  import mem_arbiter_pkg::*;
(
  input  logic [23:0]           low_bytes_i,
  input  logic [7:0]            last_byte_i,
  input  logic [2:0]            nbytes_i,
  input  logic                  is_signed_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic ext;

  always_comb begin
    ext    = is_signed_i & last_byte_i[7];
    data_o = '0;
    case (nbytes_i)
      3'd1:    data_o = {{24{ext}}, last_byte_i};
      3'd2:    data_o = {{16{ext}}, last_byte_i, low_bytes_i[7:0]};
      default: data_o = {last_byte_i, low_bytes_i};
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter between instruction fetch and load/store, loads/stores
// first. Define MEM_ARBITER_IO_STALL_EN to stall UART-window stores on a full FIFO.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  mem_arbiter_if.slave bus
);

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [2:0]            nbytes_q, nbytes_d;
  logic                  signed_q, signed_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  owner_ls_q, owner_ls_d;
  logic [23:0]           low_bytes_q, low_bytes_d;
  logic [31:0]           mem_a_q, mem_a_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  fetch_done_q, fetch_done_d;
  logic                  ls_done_q, ls_done_d;
  logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
  logic [DATA_WIDTH-1:0] ls_data_q, ls_data_d;

  logic [DATA_WIDTH-1:0] assembled;
  logic [2:0]            step_idx;
  logic [1:0]            cap_idx;
  logic [2:0]            wr_idx;
  logic [31:0]           wr_addr;
  logic                  stall_en;

`ifdef MEM_ARBITER_IO_STALL_EN
  assign stall_en = bus.io_buffer_full;
`else
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = bus.io_buffer_full;
  assign stall_en = FALSE;
`endif

  function automatic logic io_blocked(input logic en, input logic [31:0] a);
    return en && ((a & IO_BASE_MASK) == IO_BASE_MASK);
  endfunction

  mem_byte_assembler u_assembler (
    .low_bytes_i (low_bytes_q),
    .last_byte_i (bus.mem_din),
    .nbytes_i    (nbytes_q),
    .is_signed_i (signed_q),
    .data_o      (assembled)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    nbytes_d     = nbytes_q;
    signed_d     = signed_q;
    wdata_d      = wdata_q;
    owner_ls_d   = owner_ls_q;
    low_bytes_d  = low_bytes_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;
    fetch_done_d = FALSE;
    ls_done_d    = FALSE;
    fetch_data_d = fetch_data_q;
    ls_data_d    = ls_data_q;
    step_idx     = '0;
    cap_idx      = '0;
    wr_idx       = '0;
    wr_addr      = '0;

    unique case (state_q)
      StIdle: begin
        // A flush drops speculative reads; committed stores are still taken.
        if (bus.in_ls_ce && (bus.in_ls_wr || !bus.in_rob_misbranch)) begin
          addr_d     = bus.in_ls_addr;
          nbytes_d   = decode_size(bus.in_ls_size);
          signed_d   = bus.in_ls_signed;
          wdata_d    = bus.in_ls_wdata;
          owner_ls_d = TRUE;
          cnt_d      = '0;
          mem_a_d    = bus.in_ls_addr;
          if (bus.in_ls_wr) begin
            state_d = StWrite;
            if (io_blocked(stall_en, bus.in_ls_addr)) begin
              mem_wr_d = FALSE;
            end else begin
              mem_wr_d   = TRUE;
              mem_dout_d = bus.in_ls_wdata[7:0];
            end
          end else begin
            state_d = StRead;
          end
        end else if (bus.in_fetch_ce && !bus.in_rob_misbranch) begin
          addr_d     = bus.in_fetch_addr;
          nbytes_d   = 3'd4;
          signed_d   = FALSE;
          owner_ls_d = FALSE;
          cnt_d      = '0;
          mem_a_d    = bus.in_fetch_addr;
          state_d    = StRead;
        end
      end

      StRead: begin
        if (bus.in_rob_misbranch) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          // RAM answers one cycle after the address, so byte k lands two edges later.
          step_idx = cnt_q + 3'd1;
          cnt_d    = step_idx;
          if (step_idx < nbytes_q) begin
            mem_a_d = addr_q + {29'd0, step_idx};
          end
          if (step_idx >= 3'd2 && step_idx <= nbytes_q) begin
            cap_idx = step_idx[1:0] - 2'd2;
            low_bytes_d[{cap_idx, 3'b000} +: 8] = bus.mem_din;
          end
          if (step_idx == nbytes_q + 3'd1) begin
            state_d = StIdle;
            cnt_d   = '0;
            if (owner_ls_q) begin
              ls_done_d = TRUE;
              ls_data_d = assembled;
            end else begin
              fetch_done_d = TRUE;
              fetch_data_d = assembled;
            end
          end
        end
      end

      StWrite: begin
        // mem_wr_q low here means the byte at cnt_q was held back and is retried.
        wr_idx = mem_wr_q ? cnt_q + 3'd1 : cnt_q;
        if (mem_wr_q && wr_idx == nbytes_q) begin
          state_d   = StIdle;
          mem_wr_d  = FALSE;
          ls_done_d = TRUE;
          cnt_d     = '0;
        end else begin
          wr_addr = addr_q + {29'd0, wr_idx};
          mem_a_d = wr_addr;
          cnt_d   = wr_idx;
          if (io_blocked(stall_en, wr_addr)) begin
            mem_wr_d = FALSE;
          end else begin
            mem_wr_d   = TRUE;
            mem_dout_d = wdata_q[{wr_idx[1:0], 3'b000} +: 8];
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_q       <= '0;
      nbytes_q     <= 3'd4;
      signed_q     <= FALSE;
      wdata_q      <= '0;
      owner_ls_q   <= FALSE;
      low_bytes_q  <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= FALSE;
      fetch_done_q <= FALSE;
      ls_done_q    <= FALSE;
      fetch_data_q <= '0;
      ls_data_q    <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      nbytes_q     <= nbytes_d;
      signed_q     <= signed_d;
      wdata_q      <= wdata_d;
      owner_ls_q   <= owner_ls_d;
      low_bytes_q  <= low_bytes_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      fetch_done_q <= fetch_done_d;
      ls_done_q    <= ls_done_d;
      fetch_data_q <= fetch_data_d;
      ls_data_q    <= ls_data_d;
    end
  end

  assign bus.mem_a          = mem_a_q;
  assign bus.mem_dout       = mem_dout_q;
  assign bus.mem_wr         = mem_wr_q;
  assign bus.out_fetch_done = fetch_done_q;
  assign bus.out_fetch_data = fetch_data_q;
  assign bus.out_ls_done    = ls_done_q;
  assign bus.out_ls_data    = ls_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, loads, stores, priority, flush, IO stall,
// rdy freeze and reset. Cycle c means "just after the c-th edge following acceptance".
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] ram [0:262143];

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Registered-read RAM sharing the global enable with the arbiter.
  always @(posedge clk) begin
    if (rdy) begin
      if (bus.mem_wr === 1'b1) ram[bus.mem_a[17:0]] <= bus.mem_dout;
      bus.mem_din <= ram[bus.mem_a[17:0]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_ls(input logic wr, input logic [5:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata);
    bus.in_ls_ce     = 1'b1;
    bus.in_ls_wr     = wr;
    bus.in_ls_size   = size;
    bus.in_ls_signed = sgn;
    bus.in_ls_addr   = addr;
    bus.in_ls_wdata  = wdata;
    step();
    bus.in_ls_ce = 1'b0;
    bus.in_ls_wr = 1'b0;
  endtask

  task automatic issue_fetch(input logic [31:0] addr);
    bus.in_fetch_ce   = 1'b1;
    bus.in_fetch_addr = addr;
    step();
    bus.in_fetch_ce = 1'b0;
  endtask

  // Returns the cycle of the wanted done pulse (or -1), and whether the other
  // done or mem_wr was seen on the way.
  task automatic wait_done(input bit want_ls, input int start, input int limit,
                           output int cyc, output bit other_seen, output bit wr_seen);
    cyc = -1;
    other_seen = 1'b0;
    wr_seen = 1'b0;
    for (int c = start; c <= limit; c++) begin
      if (bus.mem_wr === 1'b1) wr_seen = 1'b1;
      if ((want_ls ? bus.out_fetch_done : bus.out_ls_done) === 1'b1) other_seen = 1'b1;
      if ((want_ls ? bus.out_ls_done : bus.out_fetch_done) === 1'b1) begin
        cyc = c;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== 41'd0) begin
      errors++;
      $display("FAIL reset_mem: got wr=%b a=%h dout=%h required 0/0/0",
               bus.mem_wr, bus.mem_a, bus.mem_dout);
    end
    checks++;
    if ({bus.out_fetch_done, bus.out_ls_done, bus.out_fetch_data, bus.out_ls_data} !== 66'd0)
    begin
      errors++;
      $display("FAIL reset_out: got fd=%b ld=%b fdata=%h ldata=%h required all 0",
               bus.out_fetch_done, bus.out_ls_done, bus.out_fetch_data, bus.out_ls_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    int cyc; bit other; bit wr;
    issue_fetch(32'h0000_1000);
    wait_done(1'b0, 0, 12, cyc, other, wr);
    checks++;
    if (cyc !== 5) begin
      errors++; $display("FAIL fetch_latency: got cycle %0d required 5", cyc);
    end
    checks++;
    if (bus.out_fetch_data !== 32'h0000_0513 || other || wr) begin
      errors++;
      $display("FAIL fetch_data: got %h ls_done=%b wr=%b required 00000513/0/0",
               bus.out_fetch_data, other, wr);
    end
    step();
    checks++;
    if (bus.out_fetch_done !== 1'b0) begin
      errors++; $display("FAIL fetch_pulse: got done=%b one cycle later required 0",
                         bus.out_fetch_done);
    end
  endtask

  task automatic test_load_byte();
    int cyc; bit other; bit wr;
    issue_ls(1'b0, 6'd1, 1'b1, 32'h20, 32'h0);
    wait_done(1'b1, 0, 8, cyc, other, wr);
    checks++;
    if (cyc !== 2 || bus.out_ls_data !== 32'hFFFF_FF80 || other) begin
      errors++; $display("FAIL lb: got cycle %0d data %h fetch_done=%b required 2 ffffff80 0",
                         cyc, bus.out_ls_data, other);
    end
    step();
    issue_ls(1'b0, 6'd1, 1'b0, 32'h20, 32'h0);
    wait_done(1'b1, 0, 8, cyc, other, wr);
    checks++;
    if (cyc !== 2 || bus.out_ls_data !== 32'h0000_0080) begin
      errors++; $display("FAIL lbu: got cycle %0d data %h required 2 00000080",
                         cyc, bus.out_ls_data);
    end
    step();
  endtask

  task automatic test_load_sizes();
    int cyc; bit other; bit wr;
    issue_ls(1'b0, 6'd2, 1'b1, 32'h22, 32'h0);
    wait_done(1'b1, 0, 8, cyc, other, wr);
    checks++;
    if (cyc !== 3 || bus.out_ls_data !== 32'hFFFF_C234) begin
      errors++; $display("FAIL lh: got cycle %0d data %h required 3 ffffc234",
                         cyc, bus.out_ls_data);
    end
    step();
    // Size code 7 is not a legal size and is served as a word.
    issue_ls(1'b0, 6'd7, 1'b1, 32'h40, 32'h0);
    wait_done(1'b1, 0, 10, cyc, other, wr);
    checks++;
    if (cyc !== 5 || bus.out_ls_data !== 32'h8403_0201) begin
      errors++; $display("FAIL bad_size: got cycle %0d data %h required 5 84030201",
                         cyc, bus.out_ls_data);
    end
    step();
    issue_ls(1'b0, 6'd4, 1'b0, 32'hFFFF_FFFE, 32'h0);
    wait_done(1'b1, 0, 10, cyc, other, wr);
    checks++;
    if (cyc !== 5 || bus.out_ls_data !== 32'hDDCC_BBAA) begin
      errors++; $display("FAIL addr_wrap: got cycle %0d data %h required 5 ddccbbaa",
                         cyc, bus.out_ls_data);
    end
    step();
  endtask

  task automatic test_store_priority();
    int cyc; bit other; bit wr;
    bus.in_ls_ce      = 1'b1;
    bus.in_ls_wr      = 1'b1;
    bus.in_ls_size    = 6'd4;
    bus.in_ls_signed  = 1'b0;
    bus.in_ls_addr    = 32'h100;
    bus.in_ls_wdata   = 32'h1122_3344;
    bus.in_fetch_ce   = 1'b1;
    bus.in_fetch_addr = 32'h1000;
    step();
    bus.in_ls_ce = 1'b0;
    bus.in_ls_wr = 1'b0;
    wait_done(1'b1, 0, 10, cyc, other, wr);
    checks++;
    if (cyc !== 4 || other || bus.mem_wr !== 1'b0) begin
      errors++; $display("FAIL sw_done: got cycle %0d fetch_done=%b wr=%b required 4 0 0",
                         cyc, other, bus.mem_wr);
    end
    checks++;
    if ({ram[18'h103], ram[18'h102], ram[18'h101], ram[18'h100]} !== 32'h1122_3344) begin
      errors++; $display("FAIL sw_bytes: got %h%h%h%h required 11223344",
                         ram[18'h103], ram[18'h102], ram[18'h101], ram[18'h100]);
    end
    wait_done(1'b0, cyc, 20, cyc, other, wr);
    bus.in_fetch_ce = 1'b0;
    checks++;
    if (cyc !== 10 || bus.out_fetch_data !== 32'h0000_0513) begin
      errors++; $display("FAIL fetch_after_sw: got cycle %0d data %h required 10 00000513",
                         cyc, bus.out_fetch_data);
    end
    step();
  endtask

  task automatic test_misbranch();
    int cyc; bit other; bit wr;
    issue_fetch(32'h1000);
    step();
    step();
    bus.in_rob_misbranch = 1'b1;
    step();
    bus.in_rob_misbranch = 1'b0;
    checks++;
    if (bus.out_fetch_done !== 1'b0) begin
      errors++; $display("FAIL flush_no_done: got done=%b required 0", bus.out_fetch_done);
    end
    // The arbiter must already be idle and take a new fetch right away.
    issue_fetch(32'h1004);
    wait_done(1'b0, 0, 10, cyc, other, wr);
    checks++;
    if (cyc !== 5 || bus.out_fetch_data !== 32'h0010_0093 || wr) begin
      errors++; $display("FAIL flush_refetch: got cycle %0d data %h wr=%b required 5 00100093 0",
                         cyc, bus.out_fetch_data, wr);
    end
    step();
  endtask

  task automatic test_io_stall();
    int   cyc;
    int   exp_cyc;
    logic exp_wr0;
`ifdef MEM_ARBITER_IO_STALL_EN
    exp_cyc = 4;
    exp_wr0 = 1'b0;
`else
    exp_cyc = 1;
    exp_wr0 = 1'b1;
`endif
    bus.io_buffer_full = 1'b1;
    issue_ls(1'b1, 6'd1, 1'b0, 32'h0003_0000, 32'h41);
    checks++;
    if (bus.mem_wr !== exp_wr0) begin
      errors++; $display("FAIL io_first_wr: got %b required %b", bus.mem_wr, exp_wr0);
    end
    cyc = -1;
    for (int c = 0; c <= 10; c++) begin
      if (c == 2) bus.io_buffer_full = 1'b0;
      if (bus.out_ls_done === 1'b1) begin
        cyc = c;
        break;
      end
      step();
    end
    bus.io_buffer_full = 1'b0;
    checks++;
    if (cyc !== exp_cyc || ram[18'h30000] !== 8'h41) begin
      errors++; $display("FAIL io_stall: got cycle %0d byte %h required %0d 41",
                         cyc, ram[18'h30000], exp_cyc);
    end
    step();
  endtask

  task automatic test_rdy_stall();
    int cyc; bit other; bit wr;
    issue_ls(1'b0, 6'd4, 1'b0, 32'h40, 32'h0);
    step();
    step();
    rdy = 1'b0;
    step();
    step();
    checks++;
    if (bus.mem_a !== 32'h42 || bus.out_ls_done !== 1'b0) begin
      errors++; $display("FAIL rdy_hold: got a=%h done=%b required 00000042 0",
                         bus.mem_a, bus.out_ls_done);
    end
    rdy = 1'b1;
    wait_done(1'b1, 4, 14, cyc, other, wr);
    checks++;
    if (cyc !== 7 || bus.out_ls_data !== 32'h8403_0201) begin
      errors++; $display("FAIL rdy_resume: got cycle %0d data %h required 7 84030201",
                         cyc, bus.out_ls_data);
    end
    step();
    checks++;
    if (bus.out_ls_done !== 1'b0) begin
      errors++; $display("FAIL ls_pulse: got done=%b required 0", bus.out_ls_done);
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit other; bit wr;
    issue_ls(1'b0, 6'd4, 1'b0, 32'h40, 32'h0);
    step();
    step();
    rst = 1'b1;
    rdy = 1'b0;
    step();
    checks++;
    if ({bus.mem_a, bus.out_ls_data, bus.out_fetch_data, bus.out_ls_done} !== 97'd0) begin
      errors++; $display("FAIL reset_mid: got a=%h ldata=%h fdata=%h done=%b required all 0",
                         bus.mem_a, bus.out_ls_data, bus.out_fetch_data, bus.out_ls_done);
    end
    rst = 1'b0;
    rdy = 1'b1;
    wait_done(1'b1, 0, 8, cyc, other, wr);
    checks++;
    if (cyc !== -1 || other) begin
      errors++; $display("FAIL reset_abandon: got done cycle %0d fetch_done=%b required none",
                         cyc, other);
    end
  endtask

  initial begin
    rst                  = 1'b1;
    rdy                  = 1'b1;
    bus.io_buffer_full   = 1'b0;
    bus.in_fetch_ce      = 1'b0;
    bus.in_fetch_addr    = '0;
    bus.in_ls_ce         = 1'b0;
    bus.in_ls_wr         = 1'b0;
    bus.in_ls_size       = 6'd4;
    bus.in_ls_signed     = 1'b0;
    bus.in_ls_addr       = '0;
    bus.in_ls_wdata      = '0;
    bus.in_rob_misbranch = 1'b0;
    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    {ram[18'h1003], ram[18'h1002], ram[18'h1001], ram[18'h1000]} = 32'h0000_0513;
    {ram[18'h1007], ram[18'h1006], ram[18'h1005], ram[18'h1004]} = 32'h0010_0093;
    ram[18'h20] = 8'h80;
    ram[18'h22] = 8'h34;
    ram[18'h23] = 8'hC2;
    {ram[18'h43], ram[18'h42], ram[18'h41], ram[18'h40]} = 32'h8403_0201;
    ram[18'h3FFFE] = 8'hAA;
    ram[18'h3FFFF] = 8'hBB;
    ram[18'h00000] = 8'hCC;
    ram[18'h00001] = 8'hDD;

    test_reset();
    test_fetch();
    test_load_byte();
    test_load_sizes();
    test_store_priority();
    test_misbranch();
    test_io_stall();
    test_rdy_stall();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
